// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
// Op and state encodings plus the latched operation context.
package hilo_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  typedef struct packed {
    logic is_div;
    logic neg_q;
    logic neg_r;
  } md_ctx_t;

  function automatic logic op_is_div(md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(md_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add / restoring shift-subtract unit producing {HI, LO}.
// Magnitudes are iterated; the sign is restored in a single FIX cycle.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  md_ctx_t            ctx_q, ctx_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dz_q, dz_d;

  md_op_e             op;
  logic               s1, s2;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [WIDTH-1:0]   rem_n, quo_f, rem_f;

  function automatic logic [2*WIDTH-1:0] neg_if(
    input logic n,
    input logic [2*WIDTH-1:0] v
  );
    return n ? -v : v;
  endfunction

  assign op    = md_op_e'(op_i);
  assign s1    = op_is_signed(op) & opdata1_i[WIDTH-1];
  assign s2    = op_is_signed(op) & opdata2_i[WIDTH-1];
  assign a_abs = s1 ? -opdata1_i : opdata1_i;
  assign b_abs = s2 ? -opdata2_i : opdata2_i;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (opb_q[0] ? opa_q : '0)};

  // Dividend bits enter from opa_q's MSB; the quotient grows in acc_q's LSBs.
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign rem_n    = div_diff[WIDTH] ? div_sh[WIDTH-1:0]
                                    : div_diff[WIDTH-1:0];

  assign quo_f = WIDTH'(neg_if(ctx_q.neg_q,
                   {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]}));
  assign rem_f = WIDTH'(neg_if(ctx_q.neg_r,
                   {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ctx_d   = ctx_q;
    res_d   = res_q;
    dz_d    = dz_q;
    if (annul_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            opa_d        = a_abs;
            opb_d        = b_abs;
            ctx_d.is_div = op_is_div(op);
            ctx_d.neg_q  = s1 ^ s2;
            ctx_d.neg_r  = s1;
            if (op_is_div(op) && opdata2_i == '0) begin
              state_d = ST_DONE;
              dz_d    = 1'b1;
              res_d   = {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state_d = ST_CALC;
              cnt_d   = '0;
              acc_d   = '0;
            end
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (ctx_q.is_div) begin
            acc_d = {rem_n, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            opa_d = opa_q << 1;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            opb_d = opb_q >> 1;
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          unique case (1'b1)
            ctx_q.is_div:  res_d = {rem_f, quo_f};
            !ctx_q.is_div: res_d = neg_if(ctx_q.neg_q, acc_q);
          endcase
          dz_d    = 1'b0;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      ctx_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ctx_q   <= ctx_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o     = (state_q == ST_CALC) | (state_q == ST_FIX);
  assign ready_o    = (state_q == ST_DONE);
  assign result_o   = res_q;
  assign div_zero_o = dz_q;

endmodule
